// File: rtl/latch_drv_pkg.sv
// -----------------------------------------------------------------------------
// latch_drv_pkg
// Shared definitions for the latch strobe driver:
//   - drv_state_e   : sequencer states
//   - DEF_*         : default data width and phase lengths
//   - max_phase_len : longest of the three programmable phases
//   - phase_cnt_w   : phase down-counter width derived from the phase lengths
// -----------------------------------------------------------------------------
package latch_drv_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        PULSE = 3'd2,
        HOLD  = 3'd3,
        CLEAR = 3'd4,
        CHECK = 3'd5
    } drv_state_e;

    localparam int unsigned DEF_WIDTH     = 8;
    localparam int unsigned DEF_SETUP_CYC = 2;
    localparam int unsigned DEF_PULSE_CYC = 3;
    localparam int unsigned DEF_HOLD_CYC  = 2;

    // Longest of the three phase lengths.
    function automatic int unsigned max_phase_len(input int unsigned setup_len,
                                                  input int unsigned pulse_len,
                                                  input int unsigned hold_len);
        int unsigned m;
        m = setup_len;
        if (pulse_len > m) begin
            m = pulse_len;
        end else begin
            m = m;
        end
        if (hold_len > m) begin
            m = hold_len;
        end else begin
            m = m;
        end
        return m;
    endfunction

    // Counter width: one extra bit above what the longest phase needs.
    function automatic int unsigned phase_cnt_w(input int unsigned setup_len,
                                                input int unsigned pulse_len,
                                                input int unsigned hold_len);
        return $clog2(max_phase_len(setup_len, pulse_len, hold_len)) + 1;
    endfunction

endpackage

// File: rtl/latch_strobe_driver_phase_timer.sv
// -----------------------------------------------------------------------------
// phase_timer
// Loadable down-counter that times one sequencer phase. The sequencer loads
// (phase length - 1) on phase entry; expired is high while the count is 0,
// i.e. during the last cycle of the phase.
// Ports:
//   clk      in   system clock, rising edge
//   reset    in   synchronous active-high reset (count -> 0)
//   load     in   load load_val on the next edge
//   load_val in   value to load
//   expired  out  count has reached 0
// -----------------------------------------------------------------------------
module phase_timer
    import latch_drv_pkg::*;
#(
    parameter int unsigned CNT_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             expired
);

    logic [CNT_W-1:0] cnt_q;

    // Count register: load has priority, otherwise count down and stop at 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= {CNT_W{1'b0}};
        end else if (load) begin
            cnt_q <= load_val;
        end else if (cnt_q != {CNT_W{1'b0}}) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end else begin
            cnt_q <= cnt_q;
        end
    end

    assign expired = (cnt_q == {CNT_W{1'b0}});

endmodule

// File: rtl/latch_strobe_driver.sv
// -----------------------------------------------------------------------------
// latch_strobe_driver
// Initiator for a bank of level-sensitive D latches. A word accepted over
// in_valid/in_ready is placed on lat_d, strobed with lat_enable after a setup
// window, held for a hold window, and then lat_q is compared against it.
// A clear request pulses lat_reset_n low instead. Each sequence ends with a
// one-cycle done pulse carrying the comparison result on mismatch.
// Ports:
//   clk          in   system clock, rising edge
//   reset        in   synchronous active-high reset (also clears the latch)
//   in_valid     in   write request valid
//   in_ready     out  idle, a request can be accepted
//   in_data      in   word to write [WIDTH]
//   clr_req      in   latch clear request, honoured only while idle
//   lat_d        out  latch data [WIDTH]
//   lat_enable   out  latch enable, transparent when 1
//   lat_reset_n  out  latch reset, active low
//   lat_q        in   latch readback [WIDTH]
//   done         out  one-cycle pulse at the end of a write or clear
//   mismatch     out  with done: lat_q differed from the expected word
// -----------------------------------------------------------------------------
module latch_strobe_driver
    import latch_drv_pkg::*;
#(
    parameter int unsigned WIDTH     = DEF_WIDTH,
    parameter int unsigned SETUP_CYC = DEF_SETUP_CYC,
    parameter int unsigned PULSE_CYC = DEF_PULSE_CYC,
    parameter int unsigned HOLD_CYC  = DEF_HOLD_CYC
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             clr_req,
    output logic [WIDTH-1:0] lat_d,
    output logic             lat_enable,
    output logic             lat_reset_n,
    input  logic [WIDTH-1:0] lat_q,
    output logic             done,
    output logic             mismatch
);

    localparam int unsigned CNT_W = phase_cnt_w(SETUP_CYC, PULSE_CYC, HOLD_CYC);

    localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);

    drv_state_e       state_q;
    logic [WIDTH-1:0] exp_q;
    logic [WIDTH-1:0] lat_d_q;
    logic             in_ready_q;
    logic             lat_enable_q;
    logic             lat_reset_n_q;
    logic             done_q;
    logic             mismatch_q;

    logic             timer_load_d;
    logic [CNT_W-1:0] timer_val_d;
    logic             timer_expired_s;

    // Requests are honoured only once in_ready is visible to the requester;
    // this keeps the first IDLE cycle after reset from accepting anything.
    logic             take_clr_s;
    logic             take_wr_s;

    assign take_clr_s = (state_q == IDLE) && in_ready_q && clr_req;
    assign take_wr_s  = (state_q == IDLE) && in_ready_q && !clr_req && in_valid;

    phase_timer #(
        .CNT_W (CNT_W)
    ) u_phase_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (timer_load_d),
        .load_val (timer_val_d),
        .expired  (timer_expired_s)
    );

    // Timer reload on every phase entry; mirrors the transitions below.
    always_comb begin
        timer_load_d = 1'b0;
        timer_val_d  = {CNT_W{1'b0}};
        case (state_q)
            IDLE: begin
                if (take_clr_s) begin
                    timer_load_d = 1'b1;
                    timer_val_d  = PULSE_LD;
                end else if (take_wr_s) begin
                    timer_load_d = 1'b1;
                    timer_val_d  = SETUP_LD;
                end else begin
                    timer_load_d = 1'b0;
                end
            end
            SETUP: begin
                if (timer_expired_s) begin
                    timer_load_d = 1'b1;
                    timer_val_d  = PULSE_LD;
                end else begin
                    timer_load_d = 1'b0;
                end
            end
            PULSE: begin
                if (timer_expired_s) begin
                    timer_load_d = 1'b1;
                    timer_val_d  = HOLD_LD;
                end else begin
                    timer_load_d = 1'b0;
                end
            end
            default: begin
                timer_load_d = 1'b0;
            end
        endcase
    end

    // Sequencer with registered outputs: each output is set on the edge that
    // enters the state in which it must be visible.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            exp_q         <= {WIDTH{1'b0}};
            lat_d_q       <= {WIDTH{1'b0}};
            in_ready_q    <= 1'b0;
            lat_enable_q  <= 1'b0;
            lat_reset_n_q <= 1'b0;
            done_q        <= 1'b0;
            mismatch_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q        <= 1'b0;
                    lat_enable_q  <= 1'b0;
                    if (take_clr_s) begin
                        state_q       <= CLEAR;
                        in_ready_q    <= 1'b0;
                        lat_reset_n_q <= 1'b0;
                        lat_d_q       <= {WIDTH{1'b0}};
                        exp_q         <= {WIDTH{1'b0}};
                    end else if (take_wr_s) begin
                        state_q       <= SETUP;
                        in_ready_q    <= 1'b0;
                        lat_reset_n_q <= 1'b1;
                        lat_d_q       <= in_data;
                        exp_q         <= in_data;
                    end else begin
                        in_ready_q    <= 1'b1;
                        lat_reset_n_q <= 1'b1;
                    end
                end
                SETUP: begin
                    if (timer_expired_s) begin
                        state_q      <= PULSE;
                        lat_enable_q <= 1'b1;
                    end else begin
                        state_q      <= SETUP;
                    end
                end
                PULSE: begin
                    if (timer_expired_s) begin
                        state_q      <= HOLD;
                        lat_enable_q <= 1'b0;
                    end else begin
                        state_q      <= PULSE;
                    end
                end
                HOLD: begin
                    // lat_q has been stable since the enable fell; sample it now.
                    if (timer_expired_s) begin
                        state_q    <= CHECK;
                        done_q     <= 1'b1;
                        mismatch_q <= (lat_q != exp_q);
                    end else begin
                        state_q    <= HOLD;
                    end
                end
                CLEAR: begin
                    if (timer_expired_s) begin
                        state_q       <= CHECK;
                        lat_reset_n_q <= 1'b1;
                        done_q        <= 1'b1;
                        mismatch_q    <= (lat_q != exp_q);
                    end else begin
                        state_q       <= CLEAR;
                    end
                end
                CHECK: begin
                    state_q    <= IDLE;
                    done_q     <= 1'b0;
                    in_ready_q <= 1'b1;
                end
                default: begin
                    // Unreachable encodings: park safely with the latch closed.
                    state_q       <= IDLE;
                    in_ready_q    <= 1'b0;
                    lat_enable_q  <= 1'b0;
                    lat_reset_n_q <= 1'b0;
                    done_q        <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready    = in_ready_q;
    assign lat_d       = lat_d_q;
    assign lat_enable  = lat_enable_q;
    assign lat_reset_n = lat_reset_n_q;
    assign done        = done_q;
    assign mismatch    = mismatch_q;

endmodule
